lo_sequencer: RTL and testbench

Generates the per-sample 2-bit LO code that drives the mixer's sign/zero select. It sits between the interpolator's sample strobe and the mixer. The phase counter advances once per accepted sample. Mode and phase are reconfigured glitch-free: a change to the LO pattern is applied only at a period boundary, so no partial LO cycle reaches the modulator.

---
 rtl/lo_sequencer_pkg.sv | 37 +++
 rtl/lo_pattern_lut.sv | 31 +++
 rtl/lo_sequencer.sv | 137 +++++++++++++
 tb/tb_lo_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/lo_sequencer_pkg.sv
// Shared encodings for the LO sequencer and the mixer sign/zero decode:
// mode and LO code enums plus period helpers.
package lo_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_OFF = 2'd0,
    MODE_FS4 = 2'd1,
    MODE_FS2 = 2'd2,
    MODE_DC  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    LO_ZERO = 2'b00,
    LO_POS  = 2'b01,
    LO_NEG  = 2'b10
  } lo_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  // Every period is a power of two, so period-1 doubles as the phase mask.
  function automatic logic [1:0] period_m1(input mode_e mode);
    case (mode)
      MODE_FS4: return 2'd3;
      MODE_FS2: return 2'd1;
      default:  return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] start_phase(input mode_e mode, input logic [1:0] phase);
    return phase & period_m1(mode);
  endfunction

endpackage

// File: rtl/lo_pattern_lut.sv
// Combinational (mode, phase) -> LO code lookup, plus the last phase index
// of the mode's period used for boundary detection.
module lo_pattern_lut
  import lo_sequencer_pkg::*;
(
  input  mode_e      mode,
  input  logic [1:0] phase,
  output lo_e        lo,
  output logic [1:0] last_phase
);

  // NOTE: assign a default before the case so every path drives lo and no latch is inferred.
  always_comb begin
    lo = LO_ZERO;
    case (mode)
      MODE_FS4: begin
        case (phase)
          2'd0:    lo = LO_POS;
          2'd2:    lo = LO_NEG;
          default: lo = LO_ZERO;
        endcase
      end
      MODE_FS2: lo = phase[0] ? LO_NEG : LO_POS;
      MODE_DC:  lo = LO_POS;
      default:  lo = LO_ZERO;
    endcase
  end

  assign last_phase = period_m1(mode);

endmodule

// File: rtl/lo_sequencer.sv
// Per-sample LO code generator. Reconfiguration is held in a shadow register
// and committed only at a period boundary (or when the sequencer is disabled).
module lo_sequencer
  import lo_sequencer_pkg::*;
#(
  parameter logic [1:0] RESET_MODE  = 2'd1,
  parameter logic [1:0] RESET_PHASE = 2'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] mode_i,
  input  logic [1:0] phase_i,
  input  logic       cfg_load_i,
  input  logic       sample_valid_i,
  output logic [1:0] lo_o,
  output logic       lo_valid_o,
  output logic [1:0] phase_o,
  output logic       cfg_busy_o
);

  state_e     state_q, state_d;
  mode_e      act_mode_q, act_mode_d;
  logic [1:0] act_start_q, act_start_d;
  mode_e      sh_mode_q, sh_mode_d;
  logic [1:0] sh_start_q, sh_start_d;
  logic [1:0] cnt_q, cnt_d;
  lo_e        lo_q, lo_d;
  logic [1:0] ph_out_q, ph_out_d;
  logic       lo_valid_q;

  lo_e        lut_code;
  logic [1:0] lut_last;

  lo_pattern_lut u_lut (
    .mode       (act_mode_q),
    .phase      (cnt_q),
    .lo         (lut_code),
    .last_phase (lut_last)
  );

  // NOTE: combinational next-state logic uses blocking '=' so later lines see
  // earlier updates (e.g. act_start_d); the register process below uses '<='.
  always_comb begin
    state_d     = state_q;
    act_mode_d  = act_mode_q;
    act_start_d = act_start_q;
    sh_mode_d   = sh_mode_q;
    sh_start_d  = sh_start_q;
    cnt_d       = cnt_q;
    lo_d        = lo_q;
    ph_out_d    = ph_out_q;

    case (state_q)
      ST_IDLE: begin
        lo_d     = LO_ZERO;
        ph_out_d = '0;
        if (cfg_load_i) begin
          act_mode_d  = mode_e'(mode_i);
          act_start_d = start_phase(mode_e'(mode_i), phase_i);
        end
        cnt_d = act_start_d;
        if (en_i) state_d = ST_RUN;
      end

      ST_RUN, ST_PEND: begin
        if (!en_i) begin
          // Disable: drop any in-flight code, flush the shadow, then let a
          // coincident load land on top as an ordinary idle load.
          state_d  = ST_IDLE;
          lo_d     = LO_ZERO;
          ph_out_d = '0;
          if (state_q == ST_PEND) begin
            act_mode_d  = sh_mode_q;
            act_start_d = sh_start_q;
          end
          if (cfg_load_i) begin
            act_mode_d  = mode_e'(mode_i);
            act_start_d = start_phase(mode_e'(mode_i), phase_i);
          end
          cnt_d = act_start_d;
        end else begin
          if (sample_valid_i) begin
            lo_d     = lut_code;
            ph_out_d = cnt_q;
            if (state_q == ST_PEND && cnt_q == lut_last) begin
              act_mode_d  = sh_mode_q;
              act_start_d = sh_start_q;
              cnt_d       = sh_start_q;
              state_d     = ST_RUN;
            end else begin
              cnt_d = (cnt_q == lut_last) ? 2'd0 : cnt_q + 2'd1;
            end
          end
          // A load after the boundary commit above re-arms PEND with the new value.
          if (cfg_load_i) begin
            sh_mode_d  = mode_e'(mode_i);
            sh_start_d = start_phase(mode_e'(mode_i), phase_i);
            state_d    = ST_PEND;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      act_mode_q  <= mode_e'(RESET_MODE);
      act_start_q <= start_phase(mode_e'(RESET_MODE), RESET_PHASE);
      sh_mode_q   <= MODE_OFF;
      sh_start_q  <= '0;
      cnt_q       <= start_phase(mode_e'(RESET_MODE), RESET_PHASE);
      lo_q        <= LO_ZERO;
      ph_out_q    <= '0;
      lo_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_mode_q  <= act_mode_d;
      act_start_q <= act_start_d;
      sh_mode_q   <= sh_mode_d;
      sh_start_q  <= sh_start_d;
      cnt_q       <= cnt_d;
      lo_q        <= lo_d;
      ph_out_q    <= ph_out_d;
      lo_valid_q  <= sample_valid_i;
    end
  end

  assign lo_o       = lo_q;
  assign lo_valid_o = lo_valid_q;
  assign phase_o    = ph_out_q;
  assign cfg_busy_o = (state_q == ST_PEND);

endmodule

// File: tb/tb_lo_sequencer.sv
// Table-driven bench for lo_sequencer with a strobe-to-code scoreboard and a
// hand-written asynchronous-reset sequence.
module tb_lo_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_i = 1'b0;
  logic [1:0] mode_i = '0;
  logic [1:0] phase_i = '0;
  logic       cfg_load_i = 1'b0;
  logic       sample_valid_i = 1'b0;
  logic [1:0] lo_o;
  logic       lo_valid_o;
  logic [1:0] phase_o;
  logic       cfg_busy_o;

  lo_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_i           (en_i),
    .mode_i         (mode_i),
    .phase_i        (phase_i),
    .cfg_load_i     (cfg_load_i),
    .sample_valid_i (sample_valid_i),
    .lo_o           (lo_o),
    .lo_valid_o     (lo_valid_o),
    .phase_o        (phase_o),
    .cfg_busy_o     (cfg_busy_o)
  );

  always #5 clk = ~clk;

  // Expected lo/phase are what the outputs must show after this cycle's edge;
  // an x in ph or busy means that field is not checked on this row.
  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic [1:0] phase;
    logic       load;
    logic       sv;
    logic [1:0] lo;
    logic [1:0] ph;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [1:0] lo;
    logic [1:0] ph;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic add(input logic en, input logic [1:0] mode, input logic [1:0] phase,
                     input logic load, input logic sv, input logic [1:0] lo,
                     input logic [1:0] ph, input logic busy);
    vec_t r;
    r.en = en; r.mode = mode; r.phase = phase; r.load = load;
    r.sv = sv; r.lo = lo; r.ph = ph; r.busy = busy;
    vecs.push_back(r);
  endtask

  task automatic run_vec(input vec_t r, input string tag);
    exp_t e;
    en_i           = r.en;
    mode_i         = r.mode;
    phase_i        = r.phase;
    cfg_load_i     = r.load;
    sample_valid_i = r.sv;
    if (r.sv) begin
      e.lo = r.lo;
      e.ph = r.ph;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    check({tag, " lo_valid"}, {7'd0, lo_valid_o}, {7'd0, r.sv});
    if (lo_valid_o) begin
      if (sb.size() == 0) begin
        check({tag, " sb_underflow"}, 8'd0, 8'd1);
      end else begin
        e = sb.pop_front();
        check({tag, " sb_lo"}, {6'd0, lo_o}, {6'd0, e.lo});
        if (!$isunknown(e.ph)) check({tag, " sb_phase"}, {6'd0, phase_o}, {6'd0, e.ph});
      end
    end else begin
      while (sb.size() != 0) void'(sb.pop_front());
      check({tag, " hold_lo"}, {6'd0, lo_o}, {6'd0, r.lo});
      if (!$isunknown(r.ph)) check({tag, " hold_phase"}, {6'd0, phase_o}, {6'd0, r.ph});
    end
    if (!$isunknown(r.busy)) check({tag, " busy"}, {7'd0, cfg_busy_o}, {7'd0, r.busy});
    cfg_load_i     = 1'b0;
    sample_valid_i = 1'b0;
  endtask

  initial begin
    // T1: reset defaults (fs/4, phase 0), enable, 8 back-to-back strobes.
    add(1, 0, 0, 0, 0, 2'b00, 2'd0, 0);
    add(1, 0, 0, 0, 1, 2'b01, 2'd0, 0);
    add(1, 0, 0, 0, 1, 2'b00, 2'd1, 0);
    add(1, 0, 0, 0, 1, 2'b10, 2'd2, 0);
    add(1, 0, 0, 0, 1, 2'b00, 2'd3, 0);
    add(1, 0, 0, 0, 1, 2'b01, 2'd0, 0);
    add(1, 0, 0, 0, 1, 2'b00, 2'd1, 0);
    add(1, 0, 0, 0, 1, 2'b10, 2'd2, 0);
    add(1, 0, 0, 0, 1, 2'b00, 2'd3, 0);
    // T3: strobe every third cycle, code held in between.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] code;
      code = (i == 0) ? 2'b01 : (i == 2) ? 2'b10 : 2'b00;
      add(1, 0, 0, 0, 1, code, 2'(i), 0);
      add(1, 0, 0, 0, 0, code, 2'(i), 0);
      add(1, 0, 0, 0, 0, code, 2'(i), 0);
    end
    // T2: fs/4 -> fs/2 phase 1 requested after the second strobe.
    add(1, 0, 0, 0, 1, 2'b01, 2'd0, 0);
    add(1, 0, 0, 0, 1, 2'b00, 2'd1, 0);
    add(1, 2, 1, 1, 0, 2'b00, 2'd1, 1);
    add(1, 0, 0, 0, 1, 2'b10, 2'd2, 1);
    add(1, 0, 0, 0, 1, 2'b00, 2'd3, 1'bx);
    add(1, 0, 0, 0, 1, 2'b10, 2'd1, 0);
    add(1, 0, 0, 0, 1, 2'b01, 2'd0, 0);
    add(1, 0, 0, 0, 1, 2'b10, 2'd1, 0);
    // T4: two loads in PEND (DC then off); only off is applied.
    add(1, 3, 0, 1, 0, 2'b10, 2'd1, 1);
    add(1, 0, 0, 1, 0, 2'b10, 2'd1, 1);
    add(1, 0, 0, 0, 1, 2'b01, 2'd0, 1);
    add(1, 0, 0, 0, 1, 2'b10, 2'd1, 1'bx);
    add(1, 0, 0, 0, 1, 2'b00, 2'd0, 0);
    add(1, 0, 0, 0, 1, 2'b00, 2'd0, 0);
    // T5: back to fs/4, then drop en mid-period with fs/2 pending.
    add(1, 1, 0, 1, 0, 2'b00, 2'd0, 1);
    add(1, 0, 0, 0, 1, 2'b00, 2'd0, 1'bx);
    add(1, 0, 0, 0, 1, 2'b01, 2'd0, 0);
    add(1, 0, 0, 0, 1, 2'b00, 2'd1, 0);
    add(1, 2, 0, 1, 0, 2'b00, 2'd1, 1);
    add(1, 0, 0, 0, 1, 2'b10, 2'd2, 1);
    add(0, 0, 0, 0, 0, 2'b00, 2'bxx, 0);
    add(0, 0, 0, 0, 1, 2'b00, 2'bxx, 0);
    add(1, 0, 0, 0, 0, 2'b00, 2'bxx, 0);
    add(1, 0, 0, 0, 1, 2'b01, 2'd0, 0);
    add(1, 0, 0, 0, 1, 2'b10, 2'd1, 0);
    // Load coinciding with a PEND boundary: old shadow (off) commits, DC stays pending.
    add(1, 0, 0, 1, 0, 2'b10, 2'd1, 1);
    add(1, 0, 0, 0, 1, 2'b01, 2'd0, 1);
    add(1, 3, 0, 1, 1, 2'b10, 2'd1, 1);
    add(1, 0, 0, 0, 1, 2'b00, 2'd0, 1'bx);
    add(1, 0, 0, 0, 1, 2'b01, 2'd0, 0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset lo", {6'd0, lo_o}, 8'd0);
    check("reset valid", {7'd0, lo_valid_o}, 8'd0);
    check("reset phase", {6'd0, phase_o}, 8'd0);
    check("reset busy", {7'd0, cfg_busy_o}, 8'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // T6: strobe + load so lo, valid and busy are all non-zero, then an
    // asynchronous reset between edges must clear them before the next edge.
    begin
      vec_t r;
      r.en = 1; r.mode = 2; r.phase = 0; r.load = 1; r.sv = 1;
      r.lo = 2'b01; r.ph = 2'd0; r.busy = 1;
      run_vec(r, "t6_pre");
    end
    #2 rst_n = 1'b0;
    #1;
    check("async lo", {6'd0, lo_o}, 8'd0);
    check("async valid", {7'd0, lo_valid_o}, 8'd0);
    check("async phase", {6'd0, phase_o}, 8'd0);
    check("async busy", {7'd0, cfg_busy_o}, 8'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("t6_vec%0d", i));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
